// File: rtl/dmem_responder.sv
// dmem_responder: word-wide data-memory responder for the CPU load/store port.
// A valid/ready request is accepted in IDLE, held for LATENCY wait states, then
// answered with read data (loads) or an acknowledgement (stores) plus an error
// flag. Out-of-range accesses are never written and read back as 0.
//
// Optional feature macro: DMEM_MISALIGN_CHECK_EN
//   defined   -> req_addr_i[1:0] != 0 is also flagged as an error
//   undefined -> low address bits are ignored (access to the containing word)
//
// Ports:
//   clk_i, rst_i                 rising-edge clock, synchronous active-high reset
//   req_valid_i / req_ready_o    request handshake
//   req_we_i, req_addr_i, req_wdata_i   store flag, byte address, store data
//   resp_valid_o / resp_ready_i  response handshake
//   resp_rdata_o, resp_err_o     load data (0 for stores/errors), error flag
`timescale 1ns/1ps
module dmem_responder #(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;
    localparam bit ZERO_LAT = (LATENCY == 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, valid_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          rerr_q, rerr_d;

    logic          we_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          err_q;

    logic [31:0]   mem_q [DEPTH];

    logic          accept_c;
    logic          req_err_c;
    logic          acc_c;
    logic          acc_we_c;
    logic          acc_err_c;
    logic [AW-1:0] acc_idx_c;
    logic [31:0]   acc_wdata_c;

    assign accept_c = (state_q == S_IDLE) && req_valid_i;

    // Request error: beyond the array (and optionally misaligned)
`ifdef DMEM_MISALIGN_CHECK_EN
    assign req_err_c = (req_addr_i[31:AW+2] != '0) || (req_addr_i[1:0] != 2'b00);
`else
    logic unused_c;
    assign unused_c  = ^req_addr_i[1:0];
    assign req_err_c = (req_addr_i[31:AW+2] != '0);
`endif

    // Access point: the acceptance edge when there are no wait states,
    // otherwise the last WAIT cycle using the captured request.
    assign acc_c       = ZERO_LAT ? accept_c : ((state_q == S_WAIT) && (cnt_q == CW'(1)));
    assign acc_we_c    = ZERO_LAT ? req_we_i : we_q;
    assign acc_err_c   = ZERO_LAT ? req_err_c : err_q;
    assign acc_idx_c   = ZERO_LAT ? req_addr_i[AW+1:2] : idx_q;
    assign acc_wdata_c = ZERO_LAT ? req_wdata_i : wdata_q;

    // Next-state and response data
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    cnt_d   = CW'(LATENCY);
                    state_d = ZERO_LAT ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    rerr_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (acc_c) begin
            rdata_d = (acc_we_c || acc_err_c) ? '0 : mem_q[acc_idx_c];
            rerr_d  = acc_err_c;
        end
    end

    // State, handshake outputs and captured request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == S_IDLE);
            valid_q <= (state_d == S_RESP);
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
            if (accept_c) begin
                we_q    <= req_we_i;
                idx_q   <= req_addr_i[AW+1:2];
                wdata_q <= req_wdata_i;
                err_q   <= req_err_c;
            end
        end
    end

    // Storage array: not reset; a reset edge suppresses a pending commit
    always_ff @(posedge clk_i) begin
        if (!rst_i && acc_c && acc_we_c && !acc_err_c) begin
            mem_q[acc_idx_c] <= acc_wdata_c;
        end
    end

    assign req_ready_o  = ready_q;
    assign resp_valid_o = valid_q;
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = rerr_q;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;
    localparam int unsigned DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b0;
    logic [1:0]  sel = 2'd0;

    logic [2:0]  vin, rin;
    logic [2:0]  rdy_v, vld_v, er_v;
    logic [31:0] rd_a [3];

    int n_checks = 0;
    int n_fail   = 0;
    int lat_tab [3] = '{2, 4, 0};
    logic [31:0] ref_mem [3][DEPTH];

    always #5 clk = ~clk;

    // Only the selected instance sees handshakes; the others stay idle
    assign vin[0] = req_valid && (sel == 2'd0);
    assign vin[1] = req_valid && (sel == 2'd1);
    assign vin[2] = req_valid && (sel == 2'd2);
    assign rin[0] = resp_ready && (sel == 2'd0);
    assign rin[1] = resp_ready && (sel == 2'd1);
    assign rin[2] = resp_ready && (sel == 2'd2);

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u0 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(vin[0]), .req_ready_o(rdy_v[0]),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(vld_v[0]), .resp_ready_i(rin[0]), .resp_rdata_o(rd_a[0]),
        .resp_err_o(er_v[0]));
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(4)) u1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(vin[1]), .req_ready_o(rdy_v[1]),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(vld_v[1]), .resp_ready_i(rin[1]), .resp_rdata_o(rd_a[1]),
        .resp_err_o(er_v[1]));
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(vin[2]), .req_ready_o(rdy_v[2]),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(vld_v[2]), .resp_ready_i(rin[2]), .resp_rdata_o(rd_a[2]),
        .resp_err_o(er_v[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference rules: error if beyond DEPTH words (or misaligned when enabled)
    function automatic logic exp_err(input logic [31:0] a);
        logic e;
        e = (a >= 32'(DEPTH * 4));
`ifdef DMEM_MISALIGN_CHECK_EN
        e = e || (a[1:0] != 2'b00);
`endif
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on the selected instance, checked against the model
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int stall);
        int          n;
        int          cyc;
        logic        e;
        logic [31:0] exp_rd;
        logic [6:0]  idx;
        req_valid = 1'b1;
        req_we    = w;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!rdy_v[sel] && n < 20) begin
            tick();
            n++;
        end
        check("accept_timeout", 32'(n < 20), 32'd1);
        tick();
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        idx    = a[8:2];
        e      = exp_err(a);
        exp_rd = (w || e) ? 32'd0 : ref_mem[sel][idx];
        if (w && !e) ref_mem[sel][idx] = d;
        cyc = 1;
        while (!vld_v[sel] && cyc < 40) begin
            tick();
            cyc++;
        end
        check("latency", 32'(cyc), 32'(lat_tab[sel] + 1));
        check("rdata", rd_a[sel], exp_rd);
        check("err", 32'(er_v[sel]), 32'(e));
        check("ready_busy", 32'(rdy_v[sel]), 32'd0);
        for (int s = 0; s < stall; s++) begin
            req_valid = 1'b1;
            req_addr  = $urandom_range(0, 32'h1FC);
            tick();
            check("stall_valid", 32'(vld_v[sel]), 32'd1);
            check("stall_rdata", rd_a[sel], exp_rd);
            check("stall_ready", 32'(rdy_v[sel]), 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("post_hs_ready", 32'(rdy_v[sel]), 32'd1);
        check("post_hs_valid", 32'(vld_v[sel]), 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < int'(DEPTH); i++) begin
            v = $urandom; ref_mem[0][i] = v; u0.mem_q[i] = v;
            v = $urandom; ref_mem[1][i] = v; u1.mem_q[i] = v;
            v = $urandom; ref_mem[2][i] = v; u2.mem_q[i] = v;
        end
        ref_mem[0][4] = 32'hCAFEF00D; u0.mem_q[4] = 32'hCAFEF00D;
        ref_mem[2][4] = 32'hCAFEF00D; u2.mem_q[4] = 32'hCAFEF00D;

        // Reset held two cycles with a store request pending
        rst = 1'b1; sel = 2'd0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            check("rst_ready", 32'(rdy_v[k]), 32'd1);
            check("rst_valid", 32'(vld_v[k]), 32'd0);
            check("rst_rdata", rd_a[k], 32'd0);
            check("rst_err", 32'(er_v[k]), 32'd0);
        end
        check("rst_no_write", u0.mem_q[4], ref_mem[0][4]);
        req_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Misaligned load of word 4 before it is overwritten
        txn(1'b0, 32'h13, 32'h0, 0);

        // Store then load, LATENCY=2
        txn(1'b1, 32'h10, 32'hDEADBEEF, 0);
        txn(1'b0, 32'h10, 32'h0, 0);

        // Backpressure with ignored requests during RESP
        txn(1'b0, 32'h10, 32'h0, 5);

        // Out of range store/load
        txn(1'b1, 32'h200, 32'h1234, 0);
        txn(1'b0, 32'h200, 32'h0, 1);
        check("word127_kept", u0.mem_q[127], ref_mem[0][127]);

        // Zero-latency instance
        sel = 2'd2;
        txn(1'b1, 32'h1FC, 32'hA5A5_0001, 0);
        txn(1'b0, 32'h1FC, 32'h0, 2);
        txn(1'b0, 32'h13, 32'h0, 0);

        // Reset in WAIT discards an uncommitted store (LATENCY=4)
        sel = 2'd1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midwait_ready", 32'(rdy_v[1]), 32'd1);
        check("midwait_valid", 32'(vld_v[1]), 32'd0);
        check("midwait_mem", u1.mem_q[8], ref_mem[1][8]);
        txn(1'b0, 32'h20, 32'h0, 0);

        // Randomized mix across all three latencies
        for (int t = 0; t < 40; t++) begin
            sel = 2'($urandom_range(0, 2));
            txn(1'($urandom), $urandom_range(0, 32'h23F), $urandom, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle CPU's load/store port, serving the other end of the processor's memory interface. Accepts one word-sized read or write request at a time over a valid/ready handshake, applies a programmable number of wait states, and returns read data or a write acknowledgement with an error flag. It replaces the zero-latency data memory so the core and later pipelined variants can be exercised against realistic memory timing.

## Interface

**Parameters**
- `DEPTH`, 128: number of 32-bit words. Must be a power of two, at least 2.
- `LATENCY`, 2: wait-state cycles between acceptance and response. Range 0–15.

**Ports**
- `clk_i`, input, 1: clock. All logic is rising-edge.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `req_valid_i`, input, 1: request present.
- `req_ready_o`, output, 1: responder can accept a request.
- `req_we_i`, input, 1: 1 = store, 0 = load.
- `req_addr_i`, input, 32: byte address.
- `req_wdata_i`, input, 32: store data.
- `resp_valid_o`, output, 1: response present.
- `resp_ready_i`, input, 1: requester accepts the response.
- `resp_rdata_o`, output, 32: load data. 0 for stores and errors.
- `resp_err_o`, output, 1: request was out of range or misaligned.

## Operation

- **FSM states:** IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready_o` = 1.
  - On `req_valid_i` = 1, the request is accepted. The responder registers `req_we_i`, the word index `req_addr_i[log2(DEPTH)+1:2]`, `req_wdata_i`, and the error condition, and loads the counter with `LATENCY`.
  - If `LATENCY` = 0, the next state is RESP. Otherwise it is WAIT.
- **WAIT**
  - `req_ready_o` = 0.
  - The counter decrements each cycle.
  - On the cycle the counter equals 1, the next state is RESP and the access is performed at that edge.
  - A store writes the array. A load captures the array word into `resp_rdata_o`.
- **RESP**
  - `resp_valid_o` = 1.
  - `resp_rdata_o` and `resp_err_o` are held stable until `resp_ready_i` = 1, then the next state is IDLE.
  - If `resp_ready_i` is low, the responder stays in RESP indefinitely.
- **Error condition:** `req_addr_i` ≥ DEPTH*4, or (with the macro) `req_addr_i[1:0]` ≠ 0.
  - A store in error is not written.
  - A load in error returns 0.
  - `resp_err_o` = 1.
- **Load/store ordering:** a load issued after a store to the same word returns the stored value, because the store commits before its response.
- **Memory contents** are not cleared by reset and are undefined at power-up. The bench preloads them via hierarchical access.

## Timing

- **Reset values:** state = IDLE, `req_ready_o` = 1, `resp_valid_o` = 0, `resp_rdata_o` = 0, `resp_err_o` = 0, counter = 0.
- **Latency:** the response is valid exactly LATENCY+1 cycles after the acceptance edge. With LATENCY=0, `resp_valid_o` rises the cycle after acceptance.
- **Throughput:** at most one transaction per LATENCY+2 cycles. No request is accepted while in WAIT or RESP, and IDLE is re-entered the cycle after the response handshake.
- **Input stability:** inputs need to be stable only on the acceptance edge. Changes to request inputs while `req_ready_o` = 0 are ignored.
- **Output registering:** `req_ready_o` and `resp_valid_o` are registered state decodes with no combinational path from `req_valid_i` or `resp_ready_i`.
- **Reset mid-operation:** a reset in WAIT discards the request, and a store not yet committed is not written. A reset in RESP drops the response. The responder is back in IDLE the cycle after reset deasserts.
- **Simultaneous events:** when `rst_i` and a handshake occur on the same edge, reset wins.

## Configuration

- **`DMEM_MISALIGN_CHECK_EN` defined:** a request with `req_addr_i[1:0]` ≠ 0 is flagged as an error, not written, and reads return 0.
- **Undefined:** `req_addr_i[1:0]` is ignored and the access proceeds to the containing word. Only the out-of-range check raises `resp_err_o`.

## Test plan

- **Reset:** hold `rst_i` for 2 cycles with `req_valid_i` = 1. Required: `req_ready_o` = 1, `resp_valid_o` = 0, `resp_rdata_o` = 0, no write occurs.
- **Store then load, LATENCY=2:**
  - Store 0xDEADBEEF at 0x10. Required: `resp_valid_o` rises 3 cycles after acceptance, `resp_err_o` = 0.
  - Load from 0x10. Required: `resp_rdata_o` = 0xDEADBEEF, 3 cycles after acceptance.
- **Backpressure:** load with `resp_ready_i` held low for 5 cycles. Required: `resp_valid_o` and data are stable throughout, `req_ready_o` = 0, and a new `req_valid_i` is ignored until one cycle after the handshake.
- **Out of range, DEPTH=128:** store 0x1234 at 0x200, then load from 0x200. Required: `resp_err_o` = 1 and `resp_rdata_o` = 0 for both, and word 127 is unchanged.
- **Misalignment:** load from 0x13 with word 4 preloaded as 0xCAFEF00D.
  - With `DMEM_MISALIGN_CHECK_EN`: `resp_err_o` = 1, data 0.
  - Without it: data 0xCAFEF00D, `resp_err_o` = 0.
- **Reset mid-WAIT, LATENCY=4:** assert `rst_i` 2 cycles after accepting a store of 0x55 to 0x20. Required: a subsequent load from 0x20 returns the old value, and `req_ready_o` = 1 the cycle after reset.
